// File: rtl/burst_arb_pkg.sv
// Shared types for the round-robin burst arbiter.
package burst_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    // Rotate so that bit 0 of rot corresponds to requester ptr.
    always_comb begin
        dbl     = {req, req};
        shifted = dbl >> ptr;
        rot     = shifted[N-1:0];
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        any = |req;
        idx = sum[IDW-1:0];
    end

endmodule

// File: rtl/burst_arb.sv
// Round-robin burst scheduler sharing one burst resource among N requesters.
// state | meaning
// IDLE  | no grant, arbitrating among current requests
// RUN   | one requester granted, run length counting
// LAST  | burst ended, one dead cycle before re-arbitration
module burst_arb
    import burst_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 16,
    parameter int IDW       = $clog2(N),
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           start,
    output logic           last,
    output logic           trunc,
    output logic [CW-1:0]  burst_len
);

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [CW-1:0]  run_cnt, run_cnt_n;
    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic           busy_n, start_n, last_n, trunc_n;
    logic [CW-1:0]  burst_len_n;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            run_cnt   <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            start     <= 1'b0;
            last      <= 1'b0;
            trunc     <= 1'b0;
            burst_len <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            run_cnt   <= run_cnt_n;
            gnt       <= gnt_n;
            gnt_id    <= gnt_id_n;
            busy      <= busy_n;
            start     <= start_n;
            last      <= last_n;
            trunc     <= trunc_n;
            burst_len <= burst_len_n;
        end
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        run_cnt_n   = run_cnt;
        gnt_n       = gnt;
        gnt_id_n    = gnt_id;
        busy_n      = busy;
        start_n     = 1'b0;
        last_n      = 1'b0;
        trunc_n     = 1'b0;
        burst_len_n = burst_len;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n   = RUN;
                    gnt_n     = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    gnt_id_n  = pick_idx;
                    busy_n    = 1'b1;
                    start_n   = 1'b1;
                    run_cnt_n = CW'(1);
                end
            end
            RUN: begin
                if (req[gnt_id] && (run_cnt < CW'(MAX_BURST))) begin
                    run_cnt_n = run_cnt + CW'(1);
                end else begin
                    state_n     = LAST;
                    gnt_n       = '0;
                    busy_n      = 1'b0;
                    last_n      = 1'b1;
                    trunc_n     = req[gnt_id];
                    burst_len_n = run_cnt;
                    ptr_n       = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
                end
            end
            LAST: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_arb.sv
// Randomized + directed bench for burst_arb against a burst-level reference model.
module tb_burst_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0;
    logic [2:0] req_b = '0;

    logic [3:0] gnt_a;
    logic [1:0] gnt_id_a;
    logic       busy_a, start_a, last_a, trunc_a;
    logic [4:0] len_a;

    logic [2:0] gnt_b;
    logic [1:0] gnt_id_b;
    logic       busy_b, start_b, last_b, trunc_b;
    logic [1:0] len_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    burst_arb #(.N(4), .MAX_BURST(16)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(gnt_id_a),
        .busy(busy_a), .start(start_a), .last(last_a), .trunc(trunc_a),
        .burst_len(len_a)
    );

    burst_arb #(.N(3), .MAX_BURST(2)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(gnt_id_b),
        .busy(busy_b), .start(start_b), .last(last_b), .trunc(trunc_b),
        .burst_len(len_b)
    );

    // Burst-level model: owner is the granted requester (-1 when none),
    // gap marks the mandatory dead cycle after a burst ends.
    typedef struct {
        int owner;
        int cnt;
        bit gap;
        int ptr;
        int id;
        int len;
        bit start;
        bit last;
        bit trunc;
    } model_t;

    model_t ma, mb;
    int     order_b[$];

    function automatic bit bit_of(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic mstep(inout model_t m, input logic [15:0] r, input bit rs,
                         input int n, input int mx);
        int w;
        m.start = 0;
        m.last  = 0;
        m.trunc = 0;
        if (rs) begin
            m.owner = -1; m.cnt = 0; m.gap = 0; m.ptr = 0; m.id = 0; m.len = 0;
        end else if (m.gap) begin
            m.gap = 0;
        end else if (m.owner < 0) begin
            for (int k = 0; k < n; k++) begin
                w = (m.ptr + k) % n;
                if (m.owner < 0 && bit_of(r, w)) begin
                    m.owner = w; m.id = w; m.cnt = 1; m.start = 1;
                end
            end
        end else if (bit_of(r, m.owner) && m.cnt < mx) begin
            m.cnt++;
        end else begin
            m.last  = 1;
            m.trunc = bit_of(r, m.owner);
            m.len   = m.cnt;
            m.ptr   = (m.owner + 1) % n;
            m.owner = -1;
            m.gap   = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_gnt",   32'(gnt_a),    (ma.owner >= 0) ? (32'd1 << ma.owner) : 32'd0);
        chk("a_id",    32'(gnt_id_a), 32'(ma.id));
        chk("a_busy",  32'(busy_a),   32'(ma.owner >= 0));
        chk("a_start", 32'(start_a),  32'(ma.start));
        chk("a_last",  32'(last_a),   32'(ma.last));
        chk("a_trunc", 32'(trunc_a),  32'(ma.trunc));
        chk("a_len",   32'(len_a),    32'(ma.len));
        chk("b_gnt",   32'(gnt_b),    (mb.owner >= 0) ? (32'd1 << mb.owner) : 32'd0);
        chk("b_id",    32'(gnt_id_b), 32'(mb.id));
        chk("b_busy",  32'(busy_b),   32'(mb.owner >= 0));
        chk("b_start", 32'(start_b),  32'(mb.start));
        chk("b_last",  32'(last_b),   32'(mb.last));
        chk("b_trunc", 32'(trunc_b),  32'(mb.trunc));
        chk("b_len",   32'(len_b),    32'(mb.len));
        chk("b_id_range", 32'(gnt_id_b < 2'd3), 32'd1);
    endtask

    task automatic cyc(input logic [3:0] ra, input logic [2:0] rb, input bit rs);
        req_a = ra;
        req_b = rb;
        rst   = rs;
        @(posedge clk);
        #1;
        mstep(ma, 16'(ra), rs, 4, 16);
        mstep(mb, 16'(rb), rs, 3, 2);
        check_all();
        if (start_b && !rs) order_b.push_back(int'(gnt_id_b));
    endtask

    logic [3:0] act_a;
    logic [2:0] act_b;

    initial begin
        cyc(4'b0000, 3'b000, 1'b1);
        cyc(4'b0000, 3'b000, 1'b1);

        // single requester, three-cycle burst
        repeat (3) cyc(4'b0100, 3'b000, 1'b0);
        cyc(4'b0000, 3'b000, 1'b0);
        chk("t1_last", 32'(last_a), 32'd1);
        chk("t1_len",  32'(len_a),  32'd3);
        chk("t1_trunc", 32'(trunc_a), 32'd0);
        cyc(4'b0000, 3'b000, 1'b0);

        // pointer at 3 wraps to requester 0
        cyc(4'b0011, 3'b000, 1'b0);
        chk("t3_gnt", 32'(gnt_a), 32'b0001);
        cyc(4'b0000, 3'b000, 1'b0);
        cyc(4'b0000, 3'b000, 1'b0);

        // one-cycle pulse yields burst_len 1
        cyc(4'b0010, 3'b000, 1'b0);
        chk("t4_start", 32'(start_a), 32'd1);
        cyc(4'b0000, 3'b000, 1'b0);
        chk("t4_len", 32'(len_a), 32'd1);
        cyc(4'b0000, 3'b000, 1'b0);

        // all requesting: truncated bursts rotate; N=3 instance runs alongside
        cyc(4'b0000, 3'b000, 1'b1);
        order_b.delete();
        repeat (76) cyc(4'b1111, 3'b111, 1'b0);
        chk("t6_bursts", 32'(order_b.size() >= 4), 32'd1);
        if (order_b.size() >= 4) begin
            chk("t6_order0", 32'(order_b[0]), 32'd0);
            chk("t6_order1", 32'(order_b[1]), 32'd1);
            chk("t6_order2", 32'(order_b[2]), 32'd2);
            chk("t6_order3", 32'(order_b[3]), 32'd0);
        end
        repeat (3) cyc(4'b0000, 3'b000, 1'b0);

        // reset during RUN cycle 5
        repeat (5) cyc(4'b0001, 3'b001, 1'b0);
        cyc(4'b0001, 3'b001, 1'b1);
        chk("t5_gnt",  32'(gnt_a),  32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_last", 32'(last_a), 32'd0);
        chk("t5_len",  32'(len_a),  32'd0);
        cyc(4'b1010, 3'b000, 1'b0);
        chk("t5_regrant", 32'(gnt_a), 32'b0010);
        repeat (3) cyc(4'b0000, 3'b000, 1'b0);

        // random traffic with occasional reset
        act_a = '0;
        act_b = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (act_a[i]) act_a[i] = ($urandom_range(0, 11) != 0);
                else          act_a[i] = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < 3; i++) begin
                if (act_b[i]) act_b[i] = ($urandom_range(0, 3) != 0);
                else          act_b[i] = ($urandom_range(0, 2) == 0);
            end
            cyc(act_a, act_b, $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/burst_arb.md
Name: burst_arb

Overview:
- Round-robin burst scheduler that shares one burst-oriented resource among N requesters.
- Each requester holds req high for the length of its burst. The block grants one requester at a time, tracks the run length, and caps it at MAX_BURST.
- Emits registered start/last strobes equivalent to the run/last indications of the single-stream burst detector.
- Sits in front of the shared burst datapath. gnt drives the requester-side mux select.

Parameters:
N, 4, number of requesters (2..16)
MAX_BURST, 16, maximum granted RUN cycles per burst (1..255)
IDW, $clog2(N), width of gnt_id
CW, $clog2(MAX_BURST+1), width of run counter and burst_len

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  per-requester burst request, level, held for burst duration
gnt  output  N  one-hot grant, registered, all-zero when no burst active
gnt_id  output  IDW  index of granted requester, valid while busy
busy  output  1  high in RUN state
start  output  1  one-cycle pulse on first RUN cycle of a burst
last  output  1  one-cycle pulse in the LAST state (burst ended)
trunc  output  1  one-cycle pulse with last when the burst was cut at MAX_BURST
burst_len  output  CW  granted RUN cycles of the just-ended burst; updated in LAST, held otherwise

Behaviour:
- State register encodings: IDLE=2'd0, RUN=2'd1, LAST=2'd2. Illegal encoding goes to IDLE.
- All outputs are registered and reflect the current state (assigned on the transition into a state).
- Reset: sampled on a clk edge with rst=1.
  - state=IDLE, rr pointer ptr=0, run_cnt=0.
  - gnt=0, gnt_id=0, busy=0, start=0, last=0, trunc=0, burst_len=0.
- IDLE:
  - If |req, pick winner w = first set bit of req searching ptr, ptr+1, ... wrapping mod N.
  - Next cycle: state=RUN, gnt=1<<w, gnt_id=w, busy=1, start=1, run_cnt=1.
  - If req==0, stay in IDLE.
  - Latency: req sampled in cycle k gives gnt in cycle k+1.
- RUN, evaluated each cycle using req[gnt_id] and run_cnt:
  - req[gnt_id]=1 and run_cnt<MAX_BURST: stay in RUN, run_cnt+1, start=0.
  - req[gnt_id]=0: go to LAST, trunc=0.
  - req[gnt_id]=1 and run_cnt==MAX_BURST: go to LAST, trunc=1.
  - On entry to LAST: gnt=0, busy=0, last=1, burst_len=run_cnt, ptr=(gnt_id+1) mod N.
  - run_cnt counts granted RUN cycles including the first.
- LAST:
  - Unconditional return to IDLE next cycle.
  - last and trunc deassert; burst_len holds.
  - Guarantees one dead cycle between bursts.
- Arbitration rules:
  - Requests from other requesters during RUN/LAST are ignored until IDLE; they are not queued.
  - A truncated requester that keeps req high re-competes at the lowest priority, because ptr has moved past it.
- Simultaneous events:
  - In IDLE, all req bits rising in the same cycle resolve strictly by ptr order.
  - req[gnt_id] dropping on the cycle after grant gives a burst_len=1 burst.
- Reset mid-operation: the next edge forces IDLE, gnt=0, no last pulse, ptr=0.
- Arithmetic:
  - run_cnt never exceeds MAX_BURST; no wrap.
  - ptr increment wraps mod N, and N need not be a power of two.

Decomposition:
- Package burst_arb_pkg: state encoding constants (IDLE, RUN, LAST) and the state typedef.
- Sub-module rr_pick:
  - Combinational, parameter N.
  - Inputs req[N], ptr[IDW]; outputs any, idx[IDW].
  - Rotate-and-priority-encode.
- burst_arb instantiates one rr_pick.

Test Plan:
1. After rst, req=4'b0100 held 3 cycles then 0 -> gnt=4'b0100 from cycle after first req, gnt_id=2, start at RUN cycle 1, three RUN cycles, then last=1, burst_len=3, trunc=0; ptr=3.
2. req=4'b1111 held continuously, MAX_BURST=16 -> grants rotate 0,1,2,3,0; each burst 16 RUN cycles with trunc=1, burst_len=16, one IDLE+LAST gap between bursts.
3. ptr=3 (after granting 2), req=4'b0011 asserted together -> requester 0 wins (wrap), gnt=4'b0001.
4. Single-cycle req pulse req=4'b0010 -> one RUN cycle with start=1, then last=1, burst_len=1.
5. rst asserted on RUN cycle 5 of a burst -> next cycle gnt=0, busy=0, last=0, burst_len=0; new req after reset is granted from ptr=0.
6. N=3 build, req=3'b111 held with MAX_BURST=2 -> grant order 0,1,2,0; gnt_id never reaches 3.
